// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path types: instruction/address widths, fetch buffer defaults
// and the FetchEntry record carried from the capture stage to decode.
// No ports; imported by fetch_buffer and fetch_unit.
package fetch_unit_pkg;

  localparam int INSN_WIDTH      = 32;
  localparam int INSN_ADDR_WIDTH = 32;

  typedef logic [INSN_WIDTH-1:0]      InsnPath;
  typedef logic [INSN_ADDR_WIDTH-1:0] InsnAddrPath;

  localparam int          FETCH_BUF_DEPTH = 2;
  localparam InsnAddrPath FETCH_RESET_PC  = '0;

  typedef struct packed {
    InsnPath     insn;
    InsnAddrPath pc;
  } FetchEntry;

  // Sequential fetch step; wraps modulo 2^INSN_ADDR_WIDTH.
  function automatic InsnAddrPath next_word_pc(input InsnAddrPath pc);
    return pc + INSN_ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Purpose: small FIFO of FetchEntry records between capture and decode.
// Latency: a push into an empty buffer is visible at the head the next cycle.
// Backpressure: none internally; the caller's credit rule keeps push off a full buffer.
// Ports: clk/rst; i_push + i_push_dat write the tail; i_pop consumes the head;
//        i_flush empties the buffer (wins over push/pop); o_head_vld/o_head_dat
//        expose the head register; o_count is the current occupancy.
module fetch_buffer
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  FetchEntry                  i_push_dat,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic                       o_head_vld,
  output FetchEntry                  o_head_dat,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);

  FetchEntry        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // Never pop an empty buffer, even if the caller asks.
  assign w_pop = i_pop & (r_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
    end
  end

  assign o_head_vld = (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Purpose: instruction-fetch front end; owns the PC, drives imem, buffers words for decode.
// Latency: 2 cycles reset/redirect to first outValid; 1 insn/cycle sustained.
// Backpressure: outReady=0 stops issue once buffer plus in-flight fill the credits.
// Ports: clk/rst; imemAddr/imemInsn to the registered-address instruction memory;
//        outValid/outReady/outInsn/outPC to decode; redirect/redirectPC from branch resolve.
// Optional: define FETCH_PERF_EN to add perfFetched/perfStall/perfRedirect counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter InsnAddrPath RESET_PC  = FETCH_RESET_PC,
  parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [INSN_ADDR_WIDTH-1:0] imemAddr,
  input  logic [INSN_WIDTH-1:0]      imemInsn,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [INSN_WIDTH-1:0]      outInsn,
  output logic [INSN_ADDR_WIDTH-1:0] outPC,
  input  logic                       redirect,
  input  logic [INSN_ADDR_WIDTH-1:0] redirectPC
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                perfFetched,
  output logic [31:0]                perfStall,
  output logic [31:0]                perfRedirect
`endif
);

  localparam int CNT_W = $clog2(BUF_DEPTH+1);

  InsnAddrPath      r_pc;
  logic             r_inflight;
  InsnAddrPath      r_inflight_pc;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_credit_used;
  logic             w_pop;
  logic             w_push;
  logic             w_issue;
  InsnAddrPath      w_fetch_pc;
  InsnAddrPath      w_pc_next;
  FetchEntry        w_push_entry;
  FetchEntry        w_head;

  assign w_pop = outValid & outReady;

  // Credits consumed next cycle if nothing new is issued: buffered entries plus
  // the word in flight, minus the head decode takes now. pop implies count>=1.
  assign w_credit_used = {1'b0, w_count} + (CNT_W+1)'(r_inflight) - (CNT_W+1)'(w_pop);

  // A redirect flushes the buffer and drops the in-flight word, so all credits
  // are free and it can always issue in the same cycle.
  assign w_issue = redirect | (w_credit_used < (CNT_W+1)'(BUF_DEPTH));

  // The old in-flight word belongs to the abandoned path when redirecting.
  assign w_push = r_inflight & ~redirect;

  assign w_fetch_pc = redirect ? redirectPC : r_pc;
  assign imemAddr   = w_fetch_pc;

  always_comb begin
    w_pc_next         = r_pc;
    w_push_entry.insn = imemInsn;
    w_push_entry.pc   = r_inflight_pc;
    if (w_issue) begin
      w_pc_next = next_word_pc(w_fetch_pc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= w_fetch_pc;
      end
    end
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect),
    .o_head_vld (outValid),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

  assign outInsn = w_head.insn;
  assign outPC   = w_head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched  <= '0;
      r_perf_stall    <= '0;
      r_perf_redirect <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (outValid & ~outReady) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
      if (redirect) begin
        r_perf_redirect <= r_perf_redirect + 32'd1;
      end
    end
  end

  assign perfFetched  = r_perf_fetched;
  assign perfStall    = r_perf_stall;
  assign perfRedirect = r_perf_redirect;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized ready/redirect
// traffic, scored against the expected sequential fetch stream.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemInsn;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInsn;
  logic [31:0] outPC;
  logic        redirect;
  logic [31:0] redirectPC;
`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched;
  logic [31:0] perfStall;
  logic [31:0] perfRedirect;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0),
    .BUF_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imemAddr   (imemAddr),
    .imemInsn   (imemInsn),
    .outValid   (outValid),
    .outReady   (outReady),
    .outInsn    (outInsn),
    .outPC      (outPC),
    .redirect   (redirect),
    .redirectPC (redirectPC)
`ifdef FETCH_PERF_EN
    ,
    .perfFetched  (perfFetched),
    .perfStall    (perfStall),
    .perfRedirect (perfRedirect)
`endif
  );

  // Memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16]} + 32'h1357_9BDF;
  endfunction

  // Memory registers its address: the word appears one cycle later.
  always @(posedge clk) imemInsn <= mem_word(imemAddr);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected in-order stream of PCs decode should receive.
  logic [31:0] exp_q[$];

  task automatic refill(input logic [31:0] start);
    exp_q.delete();
    for (int k = 0; k < 512; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // Monitor: scores every accepted head, checks stall stability, tracks gaps.
  int          gap = 0;
  int          max_gap = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_insn;
  logic [31:0] prev_pc;

  always @(negedge clk) begin
    if (rst) begin
      gap        = 0;
      stall_prev = 1'b0;
    end else begin
      if (!outValid) begin
        gap++;
        if (gap > max_gap) max_gap = gap;
      end else begin
        gap = 0;
      end
      if (stall_prev) begin
        chk("hold_valid", 32'(outValid), 32'd1);
        chk("hold_insn", outInsn, prev_insn);
        chk("hold_pc", outPC, prev_pc);
      end
      if (outValid && outReady) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: got pc %h with no expected entry", outPC);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          chk("out_pc", outPC, e);
          chk("out_insn", outInsn, mem_word(e));
        end
      end
      stall_prev = outValid && !outReady && !redirect;
      prev_insn  = outInsn;
      prev_pc    = outPC;
    end
  end

  // Advance to the next cycle; a redirect lasts exactly one cycle and restarts
  // the expected stream once its cycle has been scored.
  task automatic tick();
    @(posedge clk);
    if (redirect) refill(redirectPC);
    #1;
    redirect = 1'b0;
  endtask

  task automatic next_cycle();
    tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    refill(32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int since_rd;
    rst        = 1'b1;
    outReady   = 1'b1;
    redirect   = 1'b0;
    redirectPC = '0;
    refill(32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_outValid", 32'(outValid), 32'd0);
    chk("rst_outInsn", outInsn, 32'h0);
    chk("rst_outPC", outPC, 32'h0);

    // Startup latency and streaming
    do_reset();
    @(negedge clk);
    chk("c0_addr", imemAddr, 32'h0);
    chk("c0_valid", 32'(outValid), 32'd0);
    next_cycle();
    chk("c1_addr", imemAddr, 32'h4);
    chk("c1_valid", 32'(outValid), 32'd0);
    next_cycle();
    chk("c2_addr", imemAddr, 32'h8);
    chk("c2_valid", 32'(outValid), 32'd1);
    chk("c2_pc", outPC, 32'h0);
    next_cycle();
    chk("c3_addr", imemAddr, 32'hC);
    chk("c3_pc", outPC, 32'h4);

    // Stall from cycle 2: issue stops after two words
    outReady = 1'b0;
    do_reset();
    @(negedge clk);
    next_cycle();
    next_cycle();
    chk("stall_c2_addr", imemAddr, 32'h8);
    next_cycle();
    chk("stall_c3_addr", imemAddr, 32'h8);
    next_cycle();
    next_cycle();
    chk("stall_c5_addr", imemAddr, 32'h8);
    chk("stall_c5_insn", outInsn, mem_word(32'h0));
    chk("stall_c5_pc", outPC, 32'h0);
    tick();
    outReady = 1'b1;
    repeat (6) next_cycle();

    // Redirect at cycle 5
    do_reset();
    @(negedge clk);
    repeat (4) next_cycle();
    tick();
    redirect   = 1'b1;
    redirectPC = 32'h40;
    @(negedge clk);
    chk("redir_addr", imemAddr, 32'h40);
    next_cycle();
    chk("redir_c6_valid", 32'(outValid), 32'd0);
    chk("redir_c6_addr", imemAddr, 32'h44);
    next_cycle();
    chk("redir_c7_valid", 32'(outValid), 32'd1);
    chk("redir_c7_pc", outPC, 32'h40);
    next_cycle();
    chk("redir_c8_pc", outPC, 32'h44);

    // Redirect while full and stalled
    outReady = 1'b0;
    do_reset();
    @(negedge clk);
    repeat (6) next_cycle();
    tick();
    redirect   = 1'b1;
    redirectPC = 32'h100;
    @(negedge clk);
    chk("full_redir_addr", imemAddr, 32'h100);
    next_cycle();
    chk("full_redir_flushed", 32'(outValid), 32'd0);
    chk("full_redir_next_addr", imemAddr, 32'h104);
    next_cycle();
    chk("full_redir_pc", outPC, 32'h100);
    tick();
    outReady = 1'b1;
    repeat (4) next_cycle();

    // PC wrap
    tick();
    redirect   = 1'b1;
    redirectPC = 32'hFFFF_FFF8;
    repeat (8) next_cycle();

    // Asynchronous reset mid-stream
    @(negedge clk);
    chk("pre_arst_valid", 32'(outValid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(outValid), 32'd0);
    chk("arst_addr", imemAddr, 32'h0);
    do_reset();
    @(negedge clk);
    next_cycle();
    next_cycle();
    chk("arst_restart_pc", outPC, 32'h0);

    // Randomized traffic
    since_rd = 10;
    for (int i = 0; i < 3000; i++) begin
      tick();
      outReady = ($urandom_range(0, 9) < 7);
      since_rd++;
      if (since_rd >= 3 && $urandom_range(0, 19) == 0) begin
        redirect   = 1'b1;
        redirectPC = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        since_rd   = 0;
      end
    end
    tick();

`ifdef FETCH_PERF_EN
    // 10 fetches, 3 stall cycles, 1 redirect
    outReady = 1'b1;
    do_reset();
    repeat (10) tick();
    outReady = 1'b0;
    repeat (3) tick();
    outReady   = 1'b1;
    redirect   = 1'b1;
    redirectPC = 32'h200;
    tick();
    @(negedge clk);
    chk("perf_fetched", perfFetched, 32'd10);
    chk("perf_stall", perfStall, 32'd3);
    chk("perf_redirect", perfRedirect, 32'd1);
`endif

    chk("liveness_gap", 32'(max_gap <= 3), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
